thres_sched: RTL and testbench

Sequencer for the double-buffered PWM threshold memory (`thresmem`). It accepts threshold frames from a host-side valid/ready stream and writes them into the memory's write slice. At the next PWM period boundary it issues the slice-swap latch. It also continuously scans the live read slice to feed per-channel thresholds to the PWM comparators. It sits between the register/host interface and the `thresmem` + PWM counter datapath.

---
 rtl/thres_pkg.sv | 9 +
 rtl/thres_sched.sv | 120 ++++++++++++
 tb/tb_thres_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/thres_pkg.sv
// Shared types for the threshold-memory sequencer.
package thres_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } thres_state_e;

endpackage

// File: rtl/thres_sched.sv
// Fills the write slice of thresmem from a host stream, swaps slices at the
// next PWM period boundary and scans the live slice out to the comparators.
module thres_sched
  import thres_pkg::*;
#(
  parameter int unsigned pwm_width = 16,
  parameter int unsigned num_pwm   = 4,
  localparam int unsigned AW       = $clog2(num_pwm)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [pwm_width-1:0] in_data,
  input  logic                 in_last,
  input  logic                 period_start,
  output logic                 mem_write_enable,
  output logic [AW-1:0]        mem_waddr,
  output logic [pwm_width-1:0] mem_wdata,
  output logic                 mem_latch,
  output logic [AW-1:0]        mem_raddr,
  input  logic [pwm_width-1:0] mem_rdata,
  output logic                 thres_valid,
  output logic [AW-1:0]        thres_idx,
  output logic [pwm_width-1:0] thres_data,
  output logic                 frame_err,
  output logic                 armed
);

  localparam logic [AW-1:0] LAST_IDX = AW'(num_pwm - 1);

  thres_state_e   state, state_nxt;
  logic [AW-1:0]  wcnt, wcnt_nxt;
  logic [AW-1:0]  ridx;
  logic           live;
  logic           err_nxt;

  assign mem_waddr = wcnt;
  assign mem_wdata = in_data;
  assign mem_raddr = ridx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    wcnt_nxt         = wcnt;
    err_nxt          = 1'b0;
    in_ready         = 1'b0;
    armed            = 1'b0;
    mem_latch        = 1'b0;
    mem_write_enable = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_write_enable = 1'b1;
          if (wcnt == LAST_IDX) begin
            // Full count reached: a missing last marks an over-long frame.
            wcnt_nxt = '0;
            if (in_last) state_nxt = ARMED;
            else         err_nxt   = 1'b1;
          end else if (in_last) begin
            wcnt_nxt = '0;
            err_nxt  = 1'b1;
          end else begin
            wcnt_nxt = wcnt + AW'(1);
          end
        end
      end
      ARMED: begin
        armed = 1'b1;
        if (period_start) begin
          mem_latch = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Scan restarts at channel 0 on the latch so the new slice is read in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
      ridx <= '0;
    end else begin
      if (mem_latch) begin
        live <= 1'b1;
        ridx <= '0;
      end else if (live) begin
        ridx <= (ridx == LAST_IDX) ? '0 : ridx + AW'(1);
      end else begin
        ridx <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thres_valid <= 1'b0;
      thres_idx   <= '0;
      thres_data  <= '0;
    end else begin
      thres_valid <= live;
      thres_idx   <= ridx;
      thres_data  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_thres_sched.sv
// Self-checking bench for thres_sched with a behavioural double-buffered thresmem.
module tb_thres_sched;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last, period_start;
  logic [W-1:0]  in_data;
  logic          mem_write_enable, mem_latch;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [W-1:0]  mem_wdata, mem_rdata;
  logic          thres_valid;
  logic [AW-1:0] thres_idx;
  logic [W-1:0]  thres_data;
  logic          frame_err, armed;

  int checks   = 0;
  int failures = 0;

  thres_sched #(.pwm_width(W), .num_pwm(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .period_start(period_start),
    .mem_write_enable(mem_write_enable), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_latch(mem_latch), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .thres_valid(thres_valid), .thres_idx(thres_idx), .thres_data(thres_data),
    .frame_err(frame_err), .armed(armed)
  );

  always #5 clk = ~clk;

  // thresmem: writes go to the idle slice, latch swaps slices, reset selects slice 0.
  logic [W-1:0] mem_a [2][N];
  logic         sel;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel <= 1'b0;
    else begin
      if (mem_write_enable) mem_a[~sel][mem_waddr] <= mem_wdata;
      if (mem_latch) sel <= ~sel;
    end
  end
  assign mem_rdata = mem_a[sel][mem_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write scoreboard: {addr, data} pushed when a word is driven, popped on the strobe.
  logic [AW+W-1:0] exp_q [$];
  always @(negedge clk) begin
    if (rst_n && mem_write_enable) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(mem_waddr), 32'hFFFF_FFFF);
      else begin
        logic [AW+W-1:0] e;
        e = exp_q.pop_front();
        chk("waddr", 32'(mem_waddr), 32'(e[AW+W-1:W]));
        chk("wdata", 32'(mem_wdata), 32'(e[W-1:0]));
      end
    end
  end

  typedef logic [N-1:0][W-1:0] frame_t;
  frame_t cur;
  bit     live_m;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_word(input logic [W-1:0] d, input logic last, input logic ps,
                            input logic [AW-1:0] addr);
    in_valid = 1'b1; in_data = d; in_last = last; period_start = ps;
    exp_q.push_back({addr, d});
    #1;
    chk("in_ready_fill", 32'(in_ready), 32'd1);
    chk("no_latch_fill", 32'(mem_latch), 32'd0);
    tick();
    in_valid = 1'b0; in_last = 1'b0; period_start = 1'b0;
  endtask

  // Called in the latch cycle; checks two full sweeps of the new slice.
  task automatic sweep(input frame_t f);
    tick();
    period_start = 1'b0;
    tick();
    for (int k = 0; k < 2 * N; k++) begin
      chk("sweep_valid", 32'(thres_valid), 32'd1);
      chk("sweep_idx", 32'(thres_idx), 32'(k % N));
      chk("sweep_data", 32'(thres_data), 32'(f[k % N]));
      tick();
    end
  endtask

  task automatic check_old_scan();
    chk("scan_valid", 32'(thres_valid), 32'(live_m));
    if (live_m) chk("scan_data", 32'(thres_data), 32'(cur[thres_idx]));
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_latch", 32'(mem_latch), 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    chk("rst_thres_valid", 32'(thres_valid), 32'd0);
    chk("rst_thres_idx", 32'(thres_idx), 32'd0);
    chk("rst_thres_data", 32'(thres_data), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);
  endtask

  typedef struct {
    frame_t      w;
    int unsigned n;
    bit          last_on_n;
    bit          exp_err;
    bit          exp_arm;
  } vec_t;

  vec_t vecs [5];

  initial begin
    frame_t fc, fb;
    vecs[0] = '{w: {16'h0040, 16'h0030, 16'h0020, 16'h0010}, n: 4, last_on_n: 1, exp_err: 0, exp_arm: 1};
    vecs[1] = '{w: {16'h0000, 16'h0000, 16'hBEEF, 16'hDEAD}, n: 2, last_on_n: 1, exp_err: 1, exp_arm: 0};
    vecs[2] = '{w: {16'h4444, 16'h3333, 16'h2222, 16'h1111}, n: 4, last_on_n: 1, exp_err: 0, exp_arm: 1};
    vecs[3] = '{w: {16'h9004, 16'h9003, 16'h9002, 16'h9001}, n: 4, last_on_n: 0, exp_err: 1, exp_arm: 0};
    vecs[4] = '{w: {16'h0A0D, 16'h0A0C, 16'h0A0B, 16'h0A0A}, n: 4, last_on_n: 1, exp_err: 0, exp_arm: 1};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; period_start = 1'b0; in_data = '0;
    live_m = 1'b0; cur = '0;
    tick(); tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      for (int unsigned i = 0; i < vecs[v].n; i++)
        drive_word(vecs[v].w[i], (i == vecs[v].n - 1) && vecs[v].last_on_n, 1'b0, AW'(i));
      chk("frame_err", 32'(frame_err), 32'(vecs[v].exp_err));
      chk("armed", 32'(armed), 32'(vecs[v].exp_arm));
      tick();
      chk("frame_err_pulse", 32'(frame_err), 32'd0);
      period_start = 1'b1;
      #1;
      chk("latch", 32'(mem_latch), 32'(vecs[v].exp_arm));
      if (vecs[v].exp_arm) begin
        live_m = 1'b1;
        cur = vecs[v].w;
        sweep(cur);
      end else begin
        tick();
        period_start = 1'b0;
        tick();
        check_old_scan();
      end
    end

    // Final word coincides with period_start: arm only, latch on the next boundary.
    fc = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
    for (int i = 0; i < 3; i++) drive_word(fc[i], 1'b0, 1'b0, AW'(i));
    drive_word(fc[3], 1'b1, 1'b1, AW'(3));
    chk("coinc_armed", 32'(armed), 32'd1);
    tick();
    chk("coinc_still_armed", 32'(armed), 32'd1);
    check_old_scan();
    period_start = 1'b1;
    #1;
    chk("coinc_latch", 32'(mem_latch), 32'd1);
    cur = fc;
    sweep(cur);

    // Held word while armed: stalled until the latch, then becomes channel 0.
    fb = {16'hAAAD, 16'hAAAC, 16'hAAAB, 16'hAAAA};
    fb[0] = 16'h0B00; fb[1] = 16'h0B01; fb[2] = 16'h0B02; fb[3] = 16'h0B03;
    for (int i = 0; i < N; i++) drive_word(fb[i], i == N - 1, 1'b0, AW'(i));
    in_valid = 1'b1; in_data = 16'hAAAA;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_we", 32'(mem_write_enable), 32'd0);
      check_old_scan();
      tick();
    end
    period_start = 1'b1;
    #1;
    chk("hold_latch", 32'(mem_latch), 32'd1);
    chk("hold_latch_ready", 32'(in_ready), 32'd0);
    tick();
    period_start = 1'b0;
    exp_q.push_back({AW'(0), 16'hAAAA});
    #1;
    chk("hold_accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    cur = fb;
    for (int k = 0; k < N; k++) begin
      chk("hold_new_idx", 32'(thres_idx), 32'(k));
      chk("hold_new_data", 32'(thres_data), 32'(cur[k]));
      if (k > 0) begin
        drive_word(16'hAAAA + 16'(k), k == N - 1, 1'b0, AW'(k));
      end else tick();
    end
    chk("hold_rearmed", 32'(armed), 32'd1);

    // Asynchronous reset while armed discards the frame.
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick(); tick();
    rst_n = 1'b1;
    live_m = 1'b0;
    tick();
    period_start = 1'b1;
    #1;
    chk("post_rst_no_latch", 32'(mem_latch), 32'd0);
    tick();
    period_start = 1'b0;
    tick();
    chk("post_rst_no_valid", 32'(thres_valid), 32'd0);
    fc = {16'h0D04, 16'h0D03, 16'h0D02, 16'h0D01};
    for (int i = 0; i < N; i++) drive_word(fc[i], i == N - 1, 1'b0, AW'(i));
    period_start = 1'b1;
    #1;
    chk("post_rst_latch", 32'(mem_latch), 32'd1);
    cur = fc;
    sweep(cur);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
